vec_chunk_buffer: RTL and testbench

//   Ping-pong vector buffer at both ends of the MVProd chunk interface: collects the byte-serial

---
 rtl/vec_chunk_buffer_if.sv | 35 +++
 rtl/vec_chunk_buffer.sv | 109 ++++++++++
 tb/tb_vec_chunk_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vec_chunk_buffer_if.sv
// vec_chunk_buffer_if
//   Bundles the byte-serial write stream, the chunk-read controls and the
//   served chunk / status of vec_chunk_buffer.
//   master : the surrounding layers (drive writes and read controls)
//   slave  : the buffer itself
//   Signals:
//     wr_en, wr_data                    byte write strobe and signed byte
//     rd_adv, rd_ptr_rst, rd_release    advance / rewind chunk pointer, free read bank
//     out_data                          current chunk, WorkingRegs bytes, element 0 in low byte
//     out_data_ready, out_last_chunk    read bank complete / pointer on last chunk
//     wr_full, overflow                 writes currently dropped / sticky drop flag
interface vec_chunk_buffer_if #(
  parameter int WorkingRegs = 4
);
  logic                       wr_en;
  logic signed [7:0]          wr_data;
  logic                       rd_adv;
  logic                       rd_ptr_rst;
  logic                       rd_release;
  logic [WorkingRegs*8-1:0]   out_data;
  logic                       out_data_ready;
  logic                       out_last_chunk;
  logic                       wr_full;
  logic                       overflow;

  modport master (
    output wr_en, wr_data, rd_adv, rd_ptr_rst, rd_release,
    input  out_data, out_data_ready, out_last_chunk, wr_full, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_adv, rd_ptr_rst, rd_release,
    output out_data, out_data_ready, out_last_chunk, wr_full, overflow
  );
endinterface

// File: rtl/vec_chunk_buffer.sv
// vec_chunk_buffer
//   Two-bank ping-pong vector buffer. The upstream layer writes one vector
//   byte by byte into the write bank while the downstream layer reads the
//   other, complete bank in WorkingRegs-byte chunks.
//   Ports:
//     clk_in   clock, all state on the rising edge
//     rst_in   synchronous active-high reset
//     bus      vec_chunk_buffer_if.slave (write stream, read controls, chunk out, status)
//   Parameters:
//     VecLength    bytes per vector
//     WorkingRegs  bytes per served chunk
module vec_chunk_buffer #(
  parameter int VecLength   = 16,
  parameter int WorkingRegs = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  vec_chunk_buffer_if.slave  bus
);

  localparam int NumChunks = (VecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int WPW       = (VecLength > 1) ? $clog2(VecLength) : 1;
  localparam int RPW       = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  localparam logic [WPW-1:0] WrLastIdx   = WPW'(VecLength - 1);
  localparam logic [RPW-1:0] RdLastChunk = RPW'(NumChunks - 1);

  // Storage is never cleared; the full flags alone decide what may be served.
  logic [7:0]     mem [0:1][0:VecLength-1];

  logic [1:0]     full_reg;
  logic           wr_bank_reg;
  logic           rd_bank_reg;
  logic [WPW-1:0] wr_ptr_reg;
  logic [RPW-1:0] rd_ptr_reg;
  logic           overflow_reg;

  logic           wr_accept;
  logic           wr_last;
  logic           rd_ready;
  logic [WorkingRegs*8-1:0] out_data_w;

  // Full state is sampled before this cycle's update, so a write arriving in
  // the same cycle as a release of the write bank is still dropped.
  assign wr_accept = bus.wr_en && !full_reg[wr_bank_reg];
  assign wr_last   = (wr_ptr_reg == WrLastIdx);
  assign rd_ready  = full_reg[rd_bank_reg];

  always_ff @(posedge clk_in) begin
    if (wr_accept) begin
      mem[wr_bank_reg][wr_ptr_reg] <= bus.wr_data;
    end
  end

  // A completing write only ever sets the flag of an empty bank and a release
  // only clears the flag of a full bank, so the two never touch the same bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_reg     <= 2'b00;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_last) begin
          full_reg[wr_bank_reg] <= 1'b1;
          wr_ptr_reg            <= '0;
          wr_bank_reg           <= ~wr_bank_reg;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + WPW'(1);
        end
      end
      if (bus.wr_en && !wr_accept) begin
        overflow_reg <= 1'b1;
      end

      // Priority: release, then rewind, then advance; all ignored when not ready.
      if (rd_ready) begin
        if (bus.rd_release) begin
          full_reg[rd_bank_reg] <= 1'b0;
          rd_bank_reg           <= ~rd_bank_reg;
          rd_ptr_reg            <= '0;
        end else if (bus.rd_ptr_rst) begin
          rd_ptr_reg <= '0;
        end else if (bus.rd_adv) begin
          rd_ptr_reg <= (rd_ptr_reg == RdLastChunk) ? '0 : rd_ptr_reg + RPW'(1);
        end
      end
    end
  end

  // One read lane per chunk byte. Lanes past the end of the vector (only in
  // the last chunk when VecLength is not a multiple of WorkingRegs) read 0.
  for (genvar gi = 0; gi < WorkingRegs; gi++) begin : g_lane
    logic [31:0] elem_idx;
    assign elem_idx = 32'(rd_ptr_reg) * 32'(WorkingRegs) + 32'(gi);
    assign out_data_w[gi*8 +: 8] =
      (rd_ready && (elem_idx < 32'(VecLength))) ? mem[rd_bank_reg][elem_idx[WPW-1:0]] : 8'd0;
  end

  assign bus.out_data       = out_data_w;
  assign bus.out_data_ready = rd_ready;
  assign bus.out_last_chunk = rd_ready && (rd_ptr_reg == RdLastChunk);
  assign bus.wr_full        = full_reg[wr_bank_reg];
  assign bus.overflow       = overflow_reg;

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// tb_vec_chunk_buffer
//   Directed bench for vec_chunk_buffer: a VL=16/WR=4 instance for the main
//   traffic and a VL=10/WR=4 instance for the padded last chunk.
module tb_vec_chunk_buffer;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  always #5 clk_in = ~clk_in;

  vec_chunk_buffer_if #(.WorkingRegs(4)) bus ();
  vec_chunk_buffer_if #(.WorkingRegs(4)) bus_p ();

  vec_chunk_buffer #(.VecLength(16), .WorkingRegs(4)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  vec_chunk_buffer #(.VecLength(10), .WorkingRegs(4)) u_pad (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_p.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-14s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic write_pad(input logic [7:0] v);
    bus_p.wr_en   = 1'b1;
    bus_p.wr_data = v;
    tick();
    bus_p.wr_en   = 1'b0;
  endtask

  task automatic rd_pulse(input logic adv, input logic prst, input logic rel);
    bus.rd_adv     = adv;
    bus.rd_ptr_rst = prst;
    bus.rd_release = rel;
    tick();
    bus.rd_adv     = 1'b0;
    bus.rd_ptr_rst = 1'b0;
    bus.rd_release = 1'b0;
  endtask

  task automatic pad_adv();
    bus_p.rd_adv = 1'b1;
    tick();
    bus_p.rd_adv = 1'b0;
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.rd_adv = 0; bus.rd_ptr_rst = 0; bus.rd_release = 0;
    bus_p.wr_en = 0; bus_p.wr_data = 0; bus_p.rd_adv = 0; bus_p.rd_ptr_rst = 0; bus_p.rd_release = 0;

    tick();
    tick();
    rst_in = 1'b0;

    // Reset state
    check("rst_ready", 32'(bus.out_data_ready), 32'd0);
    check("rst_last",  32'(bus.out_last_chunk), 32'd0);
    check("rst_wrfull", 32'(bus.wr_full), 32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    check("rst_data",  bus.out_data, 32'h0);

    // Vector A = 1..16
    for (int i = 1; i <= 15; i++) write_byte(8'(i));
    check("a_notready", 32'(bus.out_data_ready), 32'd0);
    write_byte(8'd16);
    check("a_ready", 32'(bus.out_data_ready), 32'd1);
    check("a_chunk0", bus.out_data, 32'h04030201);
    check("a_last0", 32'(bus.out_last_chunk), 32'd0);
    check("a_wrfull", 32'(bus.wr_full), 32'd0);

    rd_pulse(1, 0, 0);
    check("a_chunk1", bus.out_data, 32'h08070605);
    rd_pulse(1, 0, 0);
    check("a_chunk2", bus.out_data, 32'h0c0b0a09);
    rd_pulse(1, 0, 0);
    check("a_chunk3", bus.out_data, 32'h100f0e0d);
    check("a_last3", 32'(bus.out_last_chunk), 32'd1);

    // Wrap and rewind
    rd_pulse(1, 0, 0);
    check("wrap_chunk0", bus.out_data, 32'h04030201);
    check("wrap_last", 32'(bus.out_last_chunk), 32'd0);
    rd_pulse(1, 0, 0);
    check("adv_chunk1", bus.out_data, 32'h08070605);
    rd_pulse(1, 1, 0);
    check("rewind", bus.out_data, 32'h04030201);

    // Vector B = 17..32 fills the second bank; a 33rd byte is dropped
    for (int i = 17; i <= 32; i++) write_byte(8'(i));
    check("b_wrfull", 32'(bus.wr_full), 32'd1);
    check("b_ovf_pre", 32'(bus.overflow), 32'd0);
    check("b_a_still", bus.out_data, 32'h04030201);
    write_byte(8'd33);
    check("drop_ovf", 32'(bus.overflow), 32'd1);
    check("drop_wrfull", 32'(bus.wr_full), 32'd1);

    // Release A: B is served
    rd_pulse(0, 0, 1);
    check("b_ready", 32'(bus.out_data_ready), 32'd1);
    check("b_chunk0", bus.out_data, 32'h14131211);
    check("b_wrfull_clr", 32'(bus.wr_full), 32'd0);

    // Fill freed bank with 50..65; last byte coincides with release of B
    for (int i = 50; i <= 64; i++) write_byte(8'(i));
    check("c_b_still", bus.out_data, 32'h14131211);
    bus.wr_en      = 1'b1;
    bus.wr_data    = 8'd65;
    bus.rd_release = 1'b1;
    tick();
    bus.wr_en      = 1'b0;
    bus.rd_release = 1'b0;
    check("c_ready", 32'(bus.out_data_ready), 32'd1);
    check("c_chunk0", bus.out_data, 32'h35343332);
    check("c_wrfull", 32'(bus.wr_full), 32'd0);
    rd_pulse(1, 0, 0);
    rd_pulse(1, 0, 0);
    rd_pulse(1, 0, 0);
    check("c_chunk3", bus.out_data, 32'h41403f3e);
    check("c_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Padded instance: VL=10 -> three chunks, last one half zero
    check("p_notready", 32'(bus_p.out_data_ready), 32'd0);
    check("p_zero", bus_p.out_data, 32'h0);
    for (int i = 1; i <= 10; i++) write_pad(8'(i));
    check("p_ready", 32'(bus_p.out_data_ready), 32'd1);
    check("p_chunk0", bus_p.out_data, 32'h04030201);
    pad_adv();
    check("p_chunk1", bus_p.out_data, 32'h08070605);
    check("p_last1", 32'(bus_p.out_last_chunk), 32'd0);
    pad_adv();
    check("p_chunk2", bus_p.out_data, 32'h00000a09);
    check("p_last2", 32'(bus_p.out_last_chunk), 32'd1);
    pad_adv();
    check("p_wrap", bus_p.out_data, 32'h04030201);

    // Reset with complete vectors held, then mid-vector reset
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("r_ready", 32'(bus.out_data_ready), 32'd0);
    check("r_data", bus.out_data, 32'h0);
    check("r_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) write_byte(8'hA0 + 8'(i));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rd_pulse(1, 0, 1);  // ignored while nothing is ready
    check("r2_ready", 32'(bus.out_data_ready), 32'd0);
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("r2_chunk0", bus.out_data, 32'h04030201);
    rd_pulse(1, 0, 0);
    rd_pulse(1, 0, 0);
    rd_pulse(1, 0, 0);
    check("r2_chunk3", bus.out_data, 32'h100f0e0d);
    check("r2_ovf", 32'(bus.overflow), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
